// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator path: envelope state encodings,
// ENV_PARAMS field layout and level limits.
package osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  // ENV_PARAMS field positions (each field is 8 bits wide)
  localparam int unsigned ENV_FIELD_W = 8;
  localparam int unsigned ENV_A_LSB   = 24;
  localparam int unsigned ENV_D_LSB   = 16;
  localparam int unsigned ENV_S_LSB   = 8;
  localparam int unsigned ENV_R_LSB   = 0;

  localparam logic [15:0] LEVEL_MAX = 16'hFFFF;

  // Rate-derived step: (x + 1) << shift, held in 17 bits
  function automatic logic [16:0] env_step(input logic [7:0] x, input int unsigned shift);
    env_step = 17'(({9'd0, x} + 17'd1) << shift);
  endfunction

  // Clamp an 18-bit signed intermediate into the 0..LEVEL_MAX range
  function automatic logic [15:0] env_sat16(input logic signed [17:0] v);
    if (v < 18'sd0)
      env_sat16 = '0;
    else if (v > 18'sh0FFFF)
      env_sat16 = LEVEL_MAX;
    else
      env_sat16 = v[15:0];
  endfunction

endpackage

// File: rtl/adsr_envelope_tick_gen.sv
// Sample-rate prescaler: TICK pulses for one CLK cycle every TICK_DIV cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1042
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_count;

  assign TICK = (r_count == CW'(TICK_DIV - 1));

  // Free-running count 0..TICK_DIV-1, wrapping on the tick cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_count <= '0;
    else if (TICK)
      r_count <= '0;
    else
      r_count <= r_count + CW'(1);
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope sequencer. Steps a 16-bit amplitude through
// IDLE/ATTACK/DECAY/SUSTAIN/RELEASE once per sample tick, driven by GATE.
module adsr_envelope
  import osc_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1042,
  parameter int unsigned RATE_SHIFT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ENV_PARAMS,
  input  logic        GATE,
  output logic [15:0] LEVEL,
  output logic [2:0]  STATE,
  output logic        ACTIVE,
  output logic        DONE
);

  logic w_tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (w_tick)
  );

  logic       r_gate_q;
  logic       w_rise;
  logic       w_fall;

  env_state_t  r_state;
  env_state_t  w_next_state;
  logic [15:0] r_level;
  logic [15:0] w_next_level;
  logic        r_done;
  logic        w_next_done;

  logic [7:0]  w_a;
  logic [7:0]  w_d;
  logic [7:0]  w_s;
  logic [7:0]  w_r;
  logic [15:0] w_target;
  logic [16:0] w_step_a;
  logic [16:0] w_step_d;
  logic [16:0] w_step_r;

  logic signed [17:0] w_level_s;
  logic signed [17:0] w_target_s;
  logic signed [17:0] w_attack_sum;
  logic signed [17:0] w_decay_diff;
  logic signed [17:0] w_release_diff;

  // Parameter fields are used live every cycle
  assign w_a      = ENV_PARAMS[ENV_A_LSB +: ENV_FIELD_W];
  assign w_d      = ENV_PARAMS[ENV_D_LSB +: ENV_FIELD_W];
  assign w_s      = ENV_PARAMS[ENV_S_LSB +: ENV_FIELD_W];
  assign w_r      = ENV_PARAMS[ENV_R_LSB +: ENV_FIELD_W];
  assign w_target = {w_s, w_s};

  assign w_step_a = env_step(w_a, RATE_SHIFT);
  assign w_step_d = env_step(w_d, RATE_SHIFT);
  assign w_step_r = env_step(w_r, RATE_SHIFT);

  assign w_level_s      = $signed({2'b00, r_level});
  assign w_target_s     = $signed({2'b00, w_target});
  assign w_attack_sum   = w_level_s + $signed({1'b0, w_step_a});
  assign w_decay_diff   = w_level_s - $signed({1'b0, w_step_d});
  assign w_release_diff = w_level_s - $signed({1'b0, w_step_r});

  assign w_rise = GATE & ~r_gate_q;
  assign w_fall = ~GATE & r_gate_q;

  // Gate history for edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_gate_q <= 1'b0;
    else
      r_gate_q <= GATE;
  end

  // State, level and completion pulse registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_level <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_level <= w_next_level;
      r_done  <= w_next_done;
    end
  end

  // Next-state and level: gate edges take priority and swallow a coincident tick
  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    w_next_done  = 1'b0;
    if (w_rise) begin
      w_next_state = ST_ATTACK;
    end else if (w_fall && (r_state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      w_next_state = ST_RELEASE;
    end else if (w_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          w_next_level = '0;
        end
        ST_ATTACK: begin
          if (w_attack_sum >= 18'sh0FFFF) begin
            w_next_level = LEVEL_MAX;
            w_next_state = ST_DECAY;
          end else begin
            w_next_level = env_sat16(w_attack_sum);
          end
        end
        ST_DECAY: begin
          if (w_decay_diff <= w_target_s) begin
            w_next_level = w_target;
            w_next_state = ST_SUSTAIN;
          end else begin
            w_next_level = env_sat16(w_decay_diff);
          end
        end
        ST_SUSTAIN: begin
          w_next_level = w_target;
        end
        ST_RELEASE: begin
          if (w_release_diff <= 18'sd0) begin
            w_next_level = '0;
            w_next_state = ST_IDLE;
            w_next_done  = 1'b1;
          end else begin
            w_next_level = env_sat16(w_release_diff);
          end
        end
        default: begin
          w_next_level = '0;
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  assign LEVEL  = r_level;
  assign STATE  = r_state;
  assign ACTIVE = (r_state != ST_IDLE);
  assign DONE   = r_done;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with TICK_DIV=4, RATE_SHIFT=4.
module tb_adsr_envelope;

  localparam int unsigned TD = 4;
  localparam int unsigned RS = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ENV_PARAMS;
  logic        GATE;
  logic [15:0] LEVEL;
  logic [2:0]  STATE;
  logic        ACTIVE;
  logic        DONE;

  int checks = 0;
  int errors = 0;
  int unsigned edge_n;

  adsr_envelope #(
    .TICK_DIV   (TD),
    .RATE_SHIFT (RS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENV_PARAMS (ENV_PARAMS),
    .GATE       (GATE),
    .LEVEL      (LEVEL),
    .STATE      (STATE),
    .ACTIVE     (ACTIVE),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  // Bench-side count of rising edges since reset release; edge k carries a tick when k % TD == 0
  always @(posedge CLK or posedge RST) begin
    if (RST) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // Advance to the falling edge after the n-th further tick edge
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge CLK); while ((edge_n % TD) != 0);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; GATE = 1'b0; ENV_PARAMS = 32'h0;
    repeat (3) @(negedge CLK);
    checks++; if (LEVEL !== 16'h0000) begin errors++; $display("FAIL reset_level got=%h exp=%h", LEVEL, 16'h0000); end
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", STATE, 0); end
    checks++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=%b", ACTIVE, 1'b0); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=%b", DONE, 1'b0); end
    RST = 1'b0;
    wait_ticks(20);
    checks++; if (LEVEL !== 16'h0000) begin errors++; $display("FAIL idle20_level got=%h exp=%h", LEVEL, 16'h0000); end
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL idle20_state got=%0d exp=%0d", STATE, 0); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL idle20_done got=%b exp=%b", DONE, 1'b0); end
  endtask

  task automatic test_full_note;
    ENV_PARAMS = 32'hFF0F80FF;
    GATE = 1'b1;
    @(negedge CLK);
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL note_attack_state got=%0d exp=%0d", STATE, 1); end
    checks++; if (LEVEL !== 16'h0000) begin errors++; $display("FAIL note_attack_start got=%h exp=%h", LEVEL, 16'h0000); end
    checks++; if (ACTIVE !== 1'b1) begin errors++; $display("FAIL note_active got=%b exp=%b", ACTIVE, 1'b1); end
    wait_ticks(15);
    checks++; if (LEVEL !== 16'hF000) begin errors++; $display("FAIL note_attack15 got=%h exp=%h", LEVEL, 16'hF000); end
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL note_attack15_state got=%0d exp=%0d", STATE, 1); end
    wait_ticks(1);
    checks++; if (LEVEL !== 16'hFFFF) begin errors++; $display("FAIL note_attack_sat got=%h exp=%h", LEVEL, 16'hFFFF); end
    checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL note_decay_state got=%0d exp=%0d", STATE, 2); end
    wait_ticks(127);
    checks++; if (LEVEL !== 16'h80FF) begin errors++; $display("FAIL note_decay127 got=%h exp=%h", LEVEL, 16'h80FF); end
    checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL note_decay127_state got=%0d exp=%0d", STATE, 2); end
    wait_ticks(1);
    checks++; if (LEVEL !== 16'h8080) begin errors++; $display("FAIL note_sustain_level got=%h exp=%h", LEVEL, 16'h8080); end
    checks++; if (STATE !== 3'd3) begin errors++; $display("FAIL note_sustain_state got=%0d exp=%0d", STATE, 3); end
    wait_ticks(2);
    checks++; if (LEVEL !== 16'h8080) begin errors++; $display("FAIL note_sustain_hold got=%h exp=%h", LEVEL, 16'h8080); end
    GATE = 1'b0;
    @(negedge CLK);
    checks++; if (STATE !== 3'd4) begin errors++; $display("FAIL note_release_state got=%0d exp=%0d", STATE, 4); end
    checks++; if (LEVEL !== 16'h8080) begin errors++; $display("FAIL note_release_hold got=%h exp=%h", LEVEL, 16'h8080); end
    wait_ticks(8);
    checks++; if (LEVEL !== 16'h0080) begin errors++; $display("FAIL note_release8 got=%h exp=%h", LEVEL, 16'h0080); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL note_release8_done got=%b exp=%b", DONE, 1'b0); end
    wait_ticks(1);
    checks++; if (LEVEL !== 16'h0000) begin errors++; $display("FAIL note_end_level got=%h exp=%h", LEVEL, 16'h0000); end
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL note_end_state got=%0d exp=%0d", STATE, 0); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL note_done_pulse got=%b exp=%b", DONE, 1'b1); end
    checks++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL note_end_active got=%b exp=%b", ACTIVE, 1'b0); end
    @(negedge CLK);
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL note_done_width got=%b exp=%b", DONE, 1'b0); end
  endtask

  task automatic test_early_release;
    GATE = 1'b1;
    @(negedge CLK);
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL early_attack_state got=%0d exp=%0d", STATE, 1); end
    wait_ticks(4);
    checks++; if (LEVEL !== 16'h4000) begin errors++; $display("FAIL early_attack4 got=%h exp=%h", LEVEL, 16'h4000); end
    GATE = 1'b0;
    @(negedge CLK);
    checks++; if (STATE !== 3'd4) begin errors++; $display("FAIL early_release_state got=%0d exp=%0d", STATE, 4); end
    wait_ticks(3);
    checks++; if (LEVEL !== 16'h1000) begin errors++; $display("FAIL early_release3 got=%h exp=%h", LEVEL, 16'h1000); end
    wait_ticks(1);
    checks++; if (LEVEL !== 16'h0000) begin errors++; $display("FAIL early_end_level got=%h exp=%h", LEVEL, 16'h0000); end
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL early_end_state got=%0d exp=%0d", STATE, 0); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL early_done got=%b exp=%b", DONE, 1'b1); end
  endtask

  task automatic test_retrigger;
    GATE = 1'b1;
    @(negedge CLK);
    wait_ticks(3);
    checks++; if (LEVEL !== 16'h3000) begin errors++; $display("FAIL retrig_attack3 got=%h exp=%h", LEVEL, 16'h3000); end
    GATE = 1'b0;
    @(negedge CLK);
    checks++; if (STATE !== 3'd4) begin errors++; $display("FAIL retrig_release_state got=%0d exp=%0d", STATE, 4); end
    GATE = 1'b1;
    @(negedge CLK);
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL retrig_state got=%0d exp=%0d", STATE, 1); end
    checks++; if (LEVEL !== 16'h3000) begin errors++; $display("FAIL retrig_keep_level got=%h exp=%h", LEVEL, 16'h3000); end
    wait_ticks(1);
    checks++; if (LEVEL !== 16'h4000) begin errors++; $display("FAIL retrig_step got=%h exp=%h", LEVEL, 16'h4000); end
  endtask

  task automatic test_coincidence_sustain;
    // Rise lands in the same cycle as a tick while releasing at 0x4000
    GATE = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    GATE = 1'b1;
    @(negedge CLK);
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL coinc_rise_state got=%0d exp=%0d", STATE, 1); end
    checks++; if (LEVEL !== 16'h4000) begin errors++; $display("FAIL coinc_rise_level got=%h exp=%h", LEVEL, 16'h4000); end
    // Fall lands on a tick while attacking
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    GATE = 1'b0;
    @(negedge CLK);
    checks++; if (STATE !== 3'd4) begin errors++; $display("FAIL coinc_fall_state got=%0d exp=%0d", STATE, 4); end
    checks++; if (LEVEL !== 16'h4000) begin errors++; $display("FAIL coinc_fall_level got=%h exp=%h", LEVEL, 16'h4000); end
    GATE = 1'b1;
    @(negedge CLK);
    wait_ticks(1);
    checks++; if (LEVEL !== 16'h5000) begin errors++; $display("FAIL coinc_next_step got=%h exp=%h", LEVEL, 16'h5000); end
    wait_ticks(10);
    checks++; if (LEVEL !== 16'hF000) begin errors++; $display("FAIL coinc_attack_f000 got=%h exp=%h", LEVEL, 16'hF000); end
    wait_ticks(1);
    checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL coinc_decay_state got=%0d exp=%0d", STATE, 2); end
    wait_ticks(128);
    checks++; if (LEVEL !== 16'h8080) begin errors++; $display("FAIL live_sustain_start got=%h exp=%h", LEVEL, 16'h8080); end
    checks++; if (STATE !== 3'd3) begin errors++; $display("FAIL live_sustain_state got=%0d exp=%0d", STATE, 3); end
    ENV_PARAMS = 32'hFF0F40FF;
    @(negedge CLK);
    checks++; if (LEVEL !== 16'h8080) begin errors++; $display("FAIL live_sustain_pre got=%h exp=%h", LEVEL, 16'h8080); end
    wait_ticks(1);
    checks++; if (LEVEL !== 16'h4040) begin errors++; $display("FAIL live_sustain_new got=%h exp=%h", LEVEL, 16'h4040); end
    checks++; if (STATE !== 3'd3) begin errors++; $display("FAIL live_sustain_new_state got=%0d exp=%0d", STATE, 3); end
  endtask

  task automatic test_reset_mid_attack;
    GATE = 1'b0;
    @(negedge CLK);
    wait_ticks(5);
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL midrst_idle got=%0d exp=%0d", STATE, 0); end
    GATE = 1'b1;
    @(negedge CLK);
    wait_ticks(8);
    checks++; if (LEVEL !== 16'h8000) begin errors++; $display("FAIL midrst_attack8 got=%h exp=%h", LEVEL, 16'h8000); end
    #2 RST = 1'b1;
    #1;
    checks++; if (LEVEL !== 16'h0000) begin errors++; $display("FAIL midrst_level got=%h exp=%h", LEVEL, 16'h0000); end
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", STATE, 0); end
    checks++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL midrst_active got=%b exp=%b", ACTIVE, 1'b0); end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL midrst_rise_state got=%0d exp=%0d", STATE, 1); end
    checks++; if (LEVEL !== 16'h0000) begin errors++; $display("FAIL midrst_rise_level got=%h exp=%h", LEVEL, 16'h0000); end
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (LEVEL !== 16'h0000) begin errors++; $display("FAIL midrst_pre_tick got=%h exp=%h", LEVEL, 16'h0000); end
    @(negedge CLK);
    checks++; if (LEVEL !== 16'h1000) begin errors++; $display("FAIL midrst_first_step got=%h exp=%h", LEVEL, 16'h1000); end
  endtask

  initial begin
    test_reset();
    test_full_note();
    test_early_release();
    test_retrigger();
    test_coincidence_sustain();
    test_reset_mid_attack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
